// File: rtl/arya_pipe_ctrl_pkg.sv
// Shared encodings for the arya hazard/forwarding controller.
package arya_pipe_ctrl_pkg;

    localparam logic [1:0] FWD_PIPE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // Flag bits carried by every shadow entry: valid, wr_en, is_load.
    localparam int unsigned SHADOW_FLAG_BITS = 3;

    function automatic int unsigned shadow_entry_width(input int unsigned addr_w);
        return addr_w + SHADOW_FLAG_BITS;
    endfunction

endpackage

// File: rtl/arya_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and advance enable.
module arya_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en && inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/arya_pipe_ctrl.sv
// Hazard, forwarding and redirect controller for the five-stage arya core.
// Tracks EX/MEM/WB destinations in a shadow scoreboard alongside the real pipe.
module arya_pipe_ctrl
    import arya_pipe_ctrl_pkg::*;
#(
    parameter int unsigned REGFILE_ADDR_WIDTH = 5,
    parameter int unsigned INST_ADDR_WIDTH    = 9,
    parameter bit          FWD_EN             = 1'b1,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1,
    parameter int unsigned COUNT_WIDTH        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          id_valid,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_R1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_R2_addr,
    input  logic                          id_R1_used,
    input  logic                          id_R2_used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] id_WR_addr,
    input  logic                          id_WR_en,
    input  logic                          id_is_load,
    input  logic                          br_taken,
    input  logic [INST_ADDR_WIDTH-1:0]    br_target,
    output logic                          stall,
    output logic                          bubble,
    output logic                          flush_fd,
    output logic                          flush_de,
    output logic                          pc_wen,
    output logic [INST_ADDR_WIDTH-1:0]    pc_target,
    output logic [1:0]                    fwd_a_sel,
    output logic [1:0]                    fwd_b_sel,
    output logic [COUNT_WIDTH-1:0]        stall_cnt,
    output logic [COUNT_WIDTH-1:0]        flush_cnt
);

    localparam int unsigned AW     = REGFILE_ADDR_WIDTH;
    localparam int unsigned EntryW = shadow_entry_width(AW);

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic          is_load;
        logic [AW-1:0] wr_addr;
    } shadow_t;

    typedef logic [EntryW-1:0] entry_t;

    entry_t        ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
    shadow_t       ex_s, mem_s, wb_s;
    logic [AW-1:0] ex_r1_addr_q, ex_r2_addr_q, ex_r1_addr_d, ex_r2_addr_d;
    logic          ex_r1_used_q, ex_r2_used_q, ex_r1_used_d, ex_r2_used_d;
    logic          hazard, redirect, kill_ex;
    logic          unused_wb_load;

    assign ex_s  = shadow_t'(ex_q);
    assign mem_s = shadow_t'(mem_q);
    assign wb_s  = shadow_t'(wb_q);
    assign unused_wb_load = wb_s.is_load;

    function automatic logic src_match(input logic used, input logic [AW-1:0] addr,
                                       input shadow_t e);
        logic zero_blocked;
        zero_blocked = ZERO_REG_HARDWIRED && (addr == '0);
        return used && e.valid && e.wr_en && (addr == e.wr_addr) && !zero_blocked;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic used, input logic [AW-1:0] addr);
        if (src_match(used, addr, mem_s) && !mem_s.is_load) begin
            return FWD_MEM;
        end else if (src_match(used, addr, wb_s)) begin
            return FWD_WB;
        end
        return FWD_PIPE;
    endfunction

    always_comb begin
        logic r1_ex, r2_ex, r1_any, r2_any;
        r1_ex  = src_match(id_R1_used, id_R1_addr, ex_s);
        r2_ex  = src_match(id_R2_used, id_R2_addr, ex_s);
        r1_any = r1_ex || src_match(id_R1_used, id_R1_addr, mem_s)
                       || src_match(id_R1_used, id_R1_addr, wb_s);
        r2_any = r2_ex || src_match(id_R2_used, id_R2_addr, mem_s)
                       || src_match(id_R2_used, id_R2_addr, wb_s);
        if (FWD_EN) begin
            hazard = (r1_ex || r2_ex) && ex_s.is_load;
        end else begin
            hazard = r1_any || r2_any;
        end
    end

    // Redirect outranks stall: the decode instruction is wrong-path anyway.
    assign redirect  = br_taken && en;
    assign stall     = hazard && id_valid && en && !br_taken;
    assign bubble    = stall;
    assign flush_fd  = redirect;
    assign flush_de  = redirect;
    assign pc_wen    = redirect;
    assign pc_target = redirect ? br_target : '0;
    assign kill_ex   = stall || redirect;

    assign fwd_a_sel = FWD_EN ? fwd_sel(ex_r1_used_q, ex_r1_addr_q) : FWD_PIPE;
    assign fwd_b_sel = FWD_EN ? fwd_sel(ex_r2_used_q, ex_r2_addr_q) : FWD_PIPE;

    always_comb begin
        wb_d         = wb_q;
        mem_d        = mem_q;
        ex_d         = ex_q;
        ex_r1_addr_d = ex_r1_addr_q;
        ex_r2_addr_d = ex_r2_addr_q;
        ex_r1_used_d = ex_r1_used_q;
        ex_r2_used_d = ex_r2_used_q;
        if (en) begin
            wb_d         = mem_q;
            mem_d        = redirect ? '0 : ex_q;
            ex_d         = kill_ex ? '0 : {id_valid, id_WR_en, id_is_load, id_WR_addr};
            ex_r1_addr_d = id_R1_addr;
            ex_r2_addr_d = id_R2_addr;
            // Source flags only count for a live instruction, so bubbles never forward.
            ex_r1_used_d = id_R1_used && id_valid && !kill_ex;
            ex_r2_used_d = id_R2_used && id_valid && !kill_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q         <= '0;
            mem_q        <= '0;
            ex_q         <= '0;
            ex_r1_addr_q <= '0;
            ex_r2_addr_q <= '0;
            ex_r1_used_q <= 1'b0;
            ex_r2_used_q <= 1'b0;
        end else begin
            wb_q         <= wb_d;
            mem_q        <= mem_d;
            ex_q         <= ex_d;
            ex_r1_addr_q <= ex_r1_addr_d;
            ex_r2_addr_q <= ex_r2_addr_d;
            ex_r1_used_q <= ex_r1_used_d;
            ex_r2_used_q <= ex_r2_used_d;
        end
    end

    arya_sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .inc  (stall),
        .count(stall_cnt)
    );

    arya_sat_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .inc  (pc_wen),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_arya_pipe_ctrl.sv
// Directed bench: a forwarding instance (16-bit counters) and a stall-only
// instance (2-bit counters) share one input stream.
module tb_arya_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset, en, id_valid;
    logic [4:0] id_R1_addr, id_R2_addr, id_WR_addr;
    logic       id_R1_used, id_R2_used, id_WR_en, id_is_load;
    logic       br_taken;
    logic [8:0] br_target;

    logic        f_stall, f_bubble, f_flush_fd, f_flush_de, f_pc_wen;
    logic [8:0]  f_pc_target;
    logic [1:0]  f_fwd_a, f_fwd_b;
    logic [15:0] f_stall_cnt, f_flush_cnt;

    logic        s_stall, s_bubble, s_flush_fd, s_flush_de, s_pc_wen;
    logic [8:0]  s_pc_target;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic [8:0]  pc;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    arya_pipe_ctrl u_fwd (
        .clk(clk), .reset(reset), .en(en), .id_valid(id_valid),
        .id_R1_addr(id_R1_addr), .id_R2_addr(id_R2_addr),
        .id_R1_used(id_R1_used), .id_R2_used(id_R2_used),
        .id_WR_addr(id_WR_addr), .id_WR_en(id_WR_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .br_target(br_target),
        .stall(f_stall), .bubble(f_bubble), .flush_fd(f_flush_fd), .flush_de(f_flush_de),
        .pc_wen(f_pc_wen), .pc_target(f_pc_target),
        .fwd_a_sel(f_fwd_a), .fwd_b_sel(f_fwd_b),
        .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt)
    );

    arya_pipe_ctrl #(
        .FWD_EN(1'b0),
        .COUNT_WIDTH(2)
    ) u_stl (
        .clk(clk), .reset(reset), .en(en), .id_valid(id_valid),
        .id_R1_addr(id_R1_addr), .id_R2_addr(id_R2_addr),
        .id_R1_used(id_R1_used), .id_R2_used(id_R2_used),
        .id_WR_addr(id_WR_addr), .id_WR_en(id_WR_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .br_target(br_target),
        .stall(s_stall), .bubble(s_bubble), .flush_fd(s_flush_fd), .flush_de(s_flush_de),
        .pc_wen(s_pc_wen), .pc_target(s_pc_target),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Simple PC register steered by the forwarding instance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= '0;
        end else if (f_pc_wen) begin
            pc <= f_pc_target;
        end else if (en && !f_stall) begin
            pc <= pc + 9'd4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic [4:0] wr,
                          input logic wen, input logic ld);
        id_valid   = v;
        id_R1_addr = r1;
        id_R1_used = u1;
        id_R2_addr = r2;
        id_R2_used = u2;
        id_WR_addr = wr;
        id_WR_en   = wen;
        id_is_load = ld;
        #1;
    endtask

    task automatic idle();
        br_taken  = 1'b0;
        br_target = '0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        en = 1'b1;
        do_reset();

        // Reset state
        check("rst_stall", f_stall, 0);
        check("rst_pc_wen", f_pc_wen, 0);
        check("rst_fwd_a", f_fwd_a, 0);
        check("rst_stall_cnt", f_stall_cnt, 0);
        check("rst_flush_cnt", f_flush_cnt, 0);
        check("rst_pc", pc, 0);

        // Load x3 then add x4,x3,x3
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        check("lu_load_nostall", f_stall, 0);
        tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        check("lu_stall", f_stall, 1);
        check("lu_bubble", f_bubble, 1);
        tick();
        check("lu_stall_done", f_stall, 0);
        tick();
        idle();
        check("lu_fwd_a_wb", f_fwd_a, 2);
        check("lu_fwd_b_wb", f_fwd_b, 2);
        check("lu_stall_cnt", f_stall_cnt, 1);
        do_reset();

        // add x5,x1,x2 then sub x6,x5,x1 on both instances
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);
        check("as_add_nostall", s_stall, 0);
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        check("as_fwd_nostall", f_stall, 0);
        check("as_stl_stall1", s_stall, 1);
        check("as_stl_fwd_a", s_fwd_a, 0);
        tick();
        check("as_fwd_a_mem", f_fwd_a, 1);
        check("as_fwd_b_pipe", f_fwd_b, 0);
        check("as_stl_stall2", s_stall, 1);
        tick();
        check("as_fwd_a_wb", f_fwd_a, 2);
        check("as_stl_stall3", s_stall, 1);
        tick();
        check("as_stl_released", s_stall, 0);
        check("as_stl_fwd_b", s_fwd_b, 0);
        check("as_stl_cnt_sat", s_stall_cnt, 3);
        check("as_fwd_cnt", f_stall_cnt, 0);
        tick();

        // Stall again on the saturated counter, then reset mid-stall
        set_id(1, 5'd6, 1, 5'd0, 0, 5'd7, 1, 0);
        check("sat_stall", s_stall, 1);
        tick();
        check("sat_hold", s_stall_cnt, 3);
        check("sat_still_stall", s_stall, 1);
        reset = 1'b0;
        tick();
        check("mid_rst_stall", s_stall, 0);
        check("mid_rst_bubble", s_bubble, 0);
        check("mid_rst_stall_cnt", s_stall_cnt, 0);
        reset = 1'b1;
        idle();
        tick();

        // Redirect coincident with a load-use hazard
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0);
        br_taken  = 1'b1;
        br_target = 9'h1A0;
        #1;
        check("br_pc_wen", f_pc_wen, 1);
        check("br_pc_target", f_pc_target, 9'h1A0);
        check("br_flush_fd", f_flush_fd, 1);
        check("br_flush_de", f_flush_de, 1);
        check("br_stall", f_stall, 0);
        check("br_bubble", f_bubble, 0);
        tick();
        br_taken = 1'b0;
        #1;
        check("br_pc", pc, 9'h1A0);
        check("br_flush_cnt", f_flush_cnt, 1);
        check("br_pc_wen_off", f_pc_wen, 0);
        check("br_ex_killed", f_stall, 0);
        do_reset();

        // x0 writes never hazard or forward
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0);
        check("x0_fwd_nostall", f_stall, 0);
        check("x0_stl_nostall", s_stall, 0);
        tick();
        check("x0_fwd_a_mem", f_fwd_a, 0);
        check("x0_stl_nostall2", s_stall, 0);
        tick();
        idle();
        check("x0_fwd_a_wb", f_fwd_a, 0);
        check("x0_fwd_b_wb", f_fwd_b, 0);
        do_reset();

        // en=0 suppresses everything and holds state
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
        en       = 1'b0;
        br_taken = 1'b1;
        br_target = 9'h0F0;
        #1;
        check("en0_stall", f_stall, 0);
        check("en0_pc_wen", f_pc_wen, 0);
        check("en0_flush_fd", f_flush_fd, 0);
        tick();
        en       = 1'b1;
        br_taken = 1'b0;
        #1;
        check("en0_state_held", f_stall, 1);
        check("en0_flush_cnt", f_flush_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
